// File: rtl/pipelined_shared_resource_pkg.sv
// Shared defaults and small elaboration helpers for the pipelined shared
// resource and its result FIFO. The defines below are the codebase-wide
// knobs; the package turns them into typed parameter defaults.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef RESOURCE_DELAY
`define RESOURCE_DELAY 4
`endif
`ifndef RESOURCE_DEPTH
`define RESOURCE_DEPTH 4
`endif
`ifndef RESOURCE_OFFSET
`define RESOURCE_OFFSET 512
`endif

package pipelined_shared_resource_pkg;

  localparam int DEF_ADDR_W = `ADDRESS_WIDTH;
  localparam int DEF_ID_W   = `ID_WIDTH;
  localparam int DEF_DATA_W = `DATA_WIDTH;
  localparam int DEF_DELAY  = `RESOURCE_DELAY;
  localparam int DEF_DEPTH  = `RESOURCE_DEPTH;
  localparam int DEF_OFFSET = `RESOURCE_OFFSET;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into a depth-entry array (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipelined_shared_resource_sync_fifo.sv
// Generic synchronous FIFO with registered storage, in-order output and a
// first-word-fall-through read port (dout shows the head whenever !empty).
// A push into a full FIFO is accepted only if a pop frees a slot that edge.

module sync_fifo
  import pipelined_shared_resource_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Next entry count from this edge's push/pop pair.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Pointers and count: the only FIFO state that needs a defined reset value.
  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage write.
  // NOTE: storage is deliberately not reset; the count marks which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pipelined_shared_resource.sv
// Pipelined shared lookup resource. Each accepted (address, id) request
// travels down a fixed DELAY-stage delay line that never stalls, then lands
// in an in-order result FIFO drained through a valid/ready port. The
// occupancy counter (in flight + queued) throttles in_ready so the FIFO can
// never overflow.

module pipelined_shared_resource
  import pipelined_shared_resource_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ID_W      = DEF_ID_W,
  parameter int DATA_W    = DEF_DATA_W,  // must be >= ADDR_W
  parameter int DELAY     = DEF_DELAY,   // must be >= 1
  parameter int DEPTH     = DEF_DEPTH,   // must be >= 1
  parameter int OFFSET    = DEF_OFFSET,
  parameter int PIPELINED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int OCC_W = occ_width(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DELAY-1:0] dl_valid_q;
  entry_t           dl_entry_q [DELAY];
  entry_t           new_entry;
  entry_t           fifo_dout;
  logic             fifo_empty, fifo_full;
  logic             accept, pop;
  logic [OCC_W-1:0] occ_q, occ_d;

  // The result is formed at acceptance; the delay line only models latency.
  assign new_entry.id   = in_id;
  assign new_entry.data = DATA_W'(in_address) + DATA_W'(OFFSET);

  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Admission: depends on occupancy only (never in_valid) and is closed during reset.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (PIPELINED != 0) in_ready = (occ_q < OCC_W'(DEPTH));
      else                in_ready = (occ_q == '0);
    end
  end

  // Occupancy next state: accept and pop on the same edge cancel out.
  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: ;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  // Delay-line valid bits; clearing them on reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_valid_q <= '0;
    end else begin
      dl_valid_q[0] <= accept;
      for (int k = 1; k < DELAY; k++) dl_valid_q[k] <= dl_valid_q[k-1];
    end
  end

  // Delay-line payload; qualified by the valid bits, so it shifts unconditionally.
  always_ff @(posedge clk) begin
    dl_entry_q[0] <= new_entry;
    for (int k = 1; k < DELAY; k++) dl_entry_q[k] <= dl_entry_q[k-1];
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dl_valid_q[DELAY-1]),
    .pop   (pop),
    .din   (dl_entry_q[DELAY-1]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Output port: zero while empty, otherwise the FIFO head (stable until popped).
  always_comb begin
    out_data = '0;
    out_id   = '0;
    if (!fifo_empty) begin
      out_data = fifo_dout.data;
      out_id   = fifo_dout.id;
    end
  end

  // Occupancy bounds in-flight + queued entries, so a push into a full FIFO is unreachable.
  fifo_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(dl_valid_q[DELAY-1] && fifo_full));

  occupancy_bound_a: assert property (@(posedge clk) disable iff (reset)
    occ_q <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_pipelined_shared_resource.sv
// Self-checking bench for pipelined_shared_resource. Four instances cover the
// parameter sets needed: A (DELAY=4, DEPTH=4) for single/backpressure/random,
// B (DEPTH=8) for back-to-back, C (PIPELINED=0) and D (ADDR_W=5, DATA_W=10,
// OFFSET=1000) for wrap and mid-operation reset.

module tb_pipelined_shared_resource;

  localparam int DELAY = 4;

  logic clk = 1'b0;
  logic rst, d_rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A
  logic [7:0] a_addr; logic [3:0] a_id; logic a_valid, a_ready;
  logic [15:0] a_data; logic [3:0] a_oid; logic a_ovalid, a_oready;
  // Instance B
  logic [7:0] b_addr; logic [3:0] b_id; logic b_valid, b_ready;
  logic [15:0] b_data; logic [3:0] b_oid; logic b_ovalid, b_oready;
  // Instance C
  logic [7:0] c_addr; logic [3:0] c_id; logic c_valid, c_ready;
  logic [15:0] c_data; logic [3:0] c_oid; logic c_ovalid, c_oready;
  // Instance D
  logic [4:0] d_addr; logic [3:0] d_id; logic d_valid, d_ready;
  logic [9:0] d_data; logic [3:0] d_oid; logic d_ovalid, d_oready;

  pipelined_shared_resource #(.ADDR_W(8), .ID_W(4), .DATA_W(16), .DELAY(DELAY),
    .DEPTH(4), .OFFSET(512), .PIPELINED(1)) dut_a (
    .clk(clk), .reset(rst), .in_address(a_addr), .in_id(a_id), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_data), .out_id(a_oid), .out_valid(a_ovalid),
    .out_ready(a_oready));

  pipelined_shared_resource #(.ADDR_W(8), .ID_W(4), .DATA_W(16), .DELAY(DELAY),
    .DEPTH(8), .OFFSET(512), .PIPELINED(1)) dut_b (
    .clk(clk), .reset(rst), .in_address(b_addr), .in_id(b_id), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_data), .out_id(b_oid), .out_valid(b_ovalid),
    .out_ready(b_oready));

  pipelined_shared_resource #(.ADDR_W(8), .ID_W(4), .DATA_W(16), .DELAY(DELAY),
    .DEPTH(4), .OFFSET(512), .PIPELINED(0)) dut_c (
    .clk(clk), .reset(rst), .in_address(c_addr), .in_id(c_id), .in_valid(c_valid),
    .in_ready(c_ready), .out_data(c_data), .out_id(c_oid), .out_valid(c_ovalid),
    .out_ready(c_oready));

  pipelined_shared_resource #(.ADDR_W(5), .ID_W(4), .DATA_W(10), .DELAY(DELAY),
    .DEPTH(4), .OFFSET(1000), .PIPELINED(1)) dut_d (
    .clk(clk), .reset(d_rst), .in_address(d_addr), .in_id(d_id), .in_valid(d_valid),
    .in_ready(d_ready), .out_data(d_data), .out_id(d_oid), .out_valid(d_ovalid),
    .out_ready(d_oready));

  // Reference model entry: expected result plus the edge it was accepted on.
  typedef struct {
    logic [15:0] data;
    logic [3:0]  id;
    int          t;
  } exp_t;

  exp_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_rst = 1'b1;
    a_valid = 0; b_valid = 0; c_valid = 0; d_valid = 0;
    a_oready = 1; b_oready = 1; c_oready = 1; d_oready = 1;
    a_addr = '0; b_addr = '0; c_addr = '0; d_addr = '0;
    a_id = '0; b_id = '0; c_id = '0; d_id = '0;
    tick(); tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b expected 0", a_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_in_ready_during: got %b expected 0", d_ready); end
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_ovalid); end
    checks++; if (a_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", a_data); end
    checks++; if (a_oid !== 4'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", a_oid); end
    rst = 1'b0; d_rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", a_ready); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL reset_c_in_ready_after: got %b expected 1", c_ready); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_in_ready_after: got %b expected 1", d_ready); end
  endtask

  task automatic test_single();
    a_oready = 1; a_addr = 8'd5; a_id = 4'd3; a_valid = 1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", a_ready); end
    tick();                                  // accept edge N
    a_valid = 0;
    for (int k = 1; k < DELAY; k++) begin
      tick();
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL single_early_valid: edge N+%0d got %b expected 0", k, a_ovalid); end
    end
    tick();                                  // edge N+DELAY
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", a_ovalid); end
    checks++; if (a_data !== 16'd517) begin errors++; $display("FAIL single_data: got %0d expected 517", a_data); end
    checks++; if (a_oid !== 4'd3) begin errors++; $display("FAIL single_id: got %0d expected 3", a_oid); end
    tick();
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", a_ovalid); end
  endtask

  task automatic test_back_to_back();
    int k;
    b_oready = 1;
    for (int s = 0; s < 13; s++) begin
      if (s < 8) begin
        b_valid = 1; b_addr = 8'(s); b_id = 4'(s);
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: step %0d got %b expected 1", s, b_ready); end
      end else begin
        b_valid = 0;
      end
      tick();
      k = s - DELAY;
      if (k >= 0 && k < 8) begin
        checks++; if (b_ovalid !== 1'b1) begin errors++; $display("FAIL b2b_valid: result %0d got %b expected 1", k, b_ovalid); end
        checks++; if (b_data !== 16'(512 + k)) begin errors++; $display("FAIL b2b_data: result %0d got %0d expected %0d", k, b_data, 512 + k); end
        checks++; if (b_oid !== 4'(k)) begin errors++; $display("FAIL b2b_id: result %0d got %0d expected %0d", k, b_oid, k); end
      end else begin
        checks++; if (b_ovalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: step %0d got %b expected 0", s, b_ovalid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] addrs [6];
    int   idx = 0;
    logic acc;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 6; i++) addrs[i] = 8'($urandom_range(0, 255));
    a_oready = 0;
    for (int t = 0; t < 12; t++) begin
      if (idx < 6) begin a_valid = 1; a_addr = addrs[idx]; a_id = 4'(idx); end
      else a_valid = 0;
      acc = a_valid && a_ready;
      tick();
      if (acc) begin
        e.data = 16'(addrs[idx]) + 16'd512; e.id = 4'(idx); e.t = cyc;
        exp_q.push_back(e); idx++;
      end
    end
    checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accept_count: got %0d expected 4", idx); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", a_ready); end
    for (int t = 0; t < 3; t++) begin
      checks++; if (exp_q.size() == 0 || a_ovalid !== 1'b1 || a_data !== exp_q[0].data) begin
        errors++; $display("FAIL bp_hold: got valid=%b data=%0d expected valid=1 data=%0d", a_ovalid, a_data, (exp_q.size() > 0) ? exp_q[0].data : 16'd0);
      end
      tick();
    end
    // One-cycle drain: slot frees on the pop edge, not combinationally.
    a_oready = 1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_no_passthrough: got %b expected 0", a_ready); end
    checks++; if (exp_q.size() == 0 || a_data !== exp_q[0].data) begin errors++; $display("FAIL bp_pop_data: got %0d", a_data); end
    tick();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    a_oready = 0;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", a_ready); end
    acc = a_valid && a_ready;
    tick();
    if (acc) begin
      e.data = 16'(addrs[idx]) + 16'd512; e.id = 4'(idx); e.t = cyc;
      exp_q.push_back(e); idx++;
    end
    a_valid = 0;
    checks++; if (idx !== 5) begin errors++; $display("FAIL bp_fifth_accept: got %0d accepted expected 5", idx); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_full_again: got %b expected 0", a_ready); end
    a_oready = 1;
    for (int t = 0; t < 20; t++) begin
      if (a_ovalid === 1'b1) begin
        checks++; if (exp_q.size() == 0 || a_data !== exp_q[0].data || a_oid !== exp_q[0].id) begin
          errors++; $display("FAIL bp_drain: got data=%0d id=%0d", a_data, a_oid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_count: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic exp_ready, exp_valid, acc, pp;
    exp_t e;
    exp_q.delete();
    for (int s = 0; s < 300; s++) begin
      exp_ready = (exp_q.size() < 4);
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].t + DELAY);
      checks++; if (a_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready: step %0d got %b expected %b", s, a_ready, exp_ready); end
      checks++; if (a_ovalid !== exp_valid) begin errors++; $display("FAIL rand_out_valid: step %0d got %b expected %b", s, a_ovalid, exp_valid); end
      if (exp_valid) begin
        checks++; if (a_data !== exp_q[0].data || a_oid !== exp_q[0].id) begin
          errors++; $display("FAIL rand_result: step %0d got %0d/%0d expected %0d/%0d", s, a_data, a_oid, exp_q[0].data, exp_q[0].id);
        end
      end
      if (s < 280) begin
        a_valid  = ($urandom_range(0, 99) < 60);
        a_oready = ($urandom_range(0, 99) < 55);
      end else begin
        a_valid = 0; a_oready = 1;
      end
      a_addr = 8'($urandom_range(0, 255));
      a_id   = 4'($urandom_range(0, 15));
      acc = a_valid && exp_ready;
      pp  = exp_valid && a_oready;
      e.data = 16'(a_addr) + 16'd512; e.id = a_id;
      tick();
      if (pp) void'(exp_q.pop_front());
      if (acc) begin e.t = cyc; exp_q.push_back(e); end
    end
    checks++; if (exp_q.size() != 0 || a_ovalid !== 1'b0) begin errors++; $display("FAIL rand_final_empty: got %0d pending valid=%b", exp_q.size(), a_ovalid); end
  endtask

  task automatic test_not_pipelined();
    int idx = 0, got = 0, pop_edge = -1;
    int acc_edge [2];
    logic acc, pp;
    acc_edge[0] = -1; acc_edge[1] = -1;
    c_oready = 1;
    for (int t = 0; t < 40 && (idx < 2 || got < 2); t++) begin
      if (idx < 2) begin c_valid = 1; c_addr = 8'(idx + 1); c_id = 4'(idx + 5); end
      else c_valid = 0;
      acc = c_valid && c_ready;
      pp  = c_ovalid && c_oready;
      if (pp) begin
        checks++; if (c_data !== 16'(512 + got + 1) || c_oid !== 4'(got + 5)) begin
          errors++; $display("FAIL np_result: got %0d/%0d expected %0d/%0d", c_data, c_oid, 512 + got + 1, got + 5);
        end
        if (got == 0) pop_edge = cyc + 1;
        got++;
      end
      tick();
      if (acc) begin acc_edge[idx] = cyc; idx++; end
    end
    c_valid = 0;
    checks++; if (idx != 2 || got != 2) begin errors++; $display("FAIL np_timeout: got %0d accepts %0d results expected 2/2", idx, got); end
    checks++; if (pop_edge != acc_edge[0] + DELAY + 1) begin errors++; $display("FAIL np_first_pop: got edge %0d expected %0d", pop_edge, acc_edge[0] + DELAY + 1); end
    checks++; if (acc_edge[1] != pop_edge + 1) begin errors++; $display("FAIL np_second_accept: got edge %0d expected %0d", acc_edge[1], pop_edge + 1); end
    checks++; if (acc_edge[1] - acc_edge[0] < DELAY + 1) begin errors++; $display("FAIL np_spacing: got %0d expected at least %0d", acc_edge[1] - acc_edge[0], DELAY + 1); end
  endtask

  task automatic test_wrap_reset();
    int waited = 0;
    d_oready = 1; d_addr = 5'd31; d_id = 4'd9; d_valid = 1;
    tick();
    d_valid = 0;
    while (d_ovalid !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++; if (d_ovalid !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got valid=%b expected 1", d_ovalid); end
    checks++; if (d_data !== 10'((31 + 1000) % 1024)) begin errors++; $display("FAIL wrap_data: got %0d expected %0d", d_data, (31 + 1000) % 1024); end
    checks++; if (d_oid !== 4'd9) begin errors++; $display("FAIL wrap_id: got %0d expected 9", d_oid); end
    tick();
    d_valid = 1; d_addr = 5'd2; d_id = 4'd1;
    tick();
    d_addr = 5'd3; d_id = 4'd2;
    tick();
    d_valid = 0;
    d_rst = 1;
    #1;
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", d_ready); end
    tick();
    d_rst = 0;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_after: got %b expected 1", d_ready); end
    for (int t = 0; t < 10; t++) begin
      checks++; if (d_ovalid !== 1'b0 || d_data !== 10'd0) begin errors++; $display("FAIL rst_stale_result: cycle %0d got valid=%b data=%0d expected 0", t, d_ovalid, d_data); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_not_pipelined();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
